// File: rtl/updn_cnt_sched_pkg.sv
// Shared types and helpers for the up/down counter scheduler.
package updn_cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

  // Index of one of the two requesters.
  typedef logic req_idx_t;

  // Round-robin pick: the requester not granted last wins a tie,
  // a lone valid wins outright.
  function automatic req_idx_t rr_pick(logic [1:0] valid, req_idx_t last);
    if (valid == 2'b11) return ~last;
    else if (valid[1])  return 1'b1;
    else                return 1'b0;
  endfunction

  function automatic logic [1:0] idx_onehot(req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/updn_cnt_sched_if.sv
// Requester-side bus of the scheduler: job handshake, abort and job status.
interface updn_cnt_sched_if #(parameter int WIDTH = 3);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] start0;
  logic [WIDTH-1:0] end0;
  logic [WIDTH-1:0] start1;
  logic [WIDTH-1:0] end1;
  logic             abort;
  logic             busy;
  logic             up_dn;
  logic [WIDTH-1:0] count;
  logic [1:0]       done;
  logic             aborted;

  modport master (
    output req_valid, start0, end0, start1, end1, abort,
    input  req_ready, busy, up_dn, count, done, aborted
  );

  modport slave (
    input  req_valid, start0, end0, start1, end1, abort,
    output req_ready, busy, up_dn, count, done, aborted
  );
endinterface

// File: rtl/updn_cnt_sched_core.sv
// Loadable up/down counter; load has priority over count enable.
module updn_cnt_core
  import updn_cnt_sched_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  // Counter register: load, else step by one in the requested direction.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count <= '0;
    end else if (ld) begin
      count <= data_in;
    end else if (en) begin
      count <= (up_dn == UP) ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/updn_cnt_sched.sv
// Two-requester round-robin scheduler driving a shared up/down counter.
// Note: reset_n is active-high despite its name.
//
// state | meaning
// IDLE  | waiting for a job, grants combinationally via req_ready
// LOAD  | counter loaded with the latched start value
// RUN   | stepping toward end; stops at end or on abort
// DONE  | one-cycle completion pulse to the job owner
module updn_cnt_sched
  import updn_cnt_sched_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  updn_cnt_sched_if.slave    bus
);

  state_t           state;
  req_idx_t         owner;      // also serves as the round-robin "last granted" pointer
  req_idx_t         gnt;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic [WIDTH-1:0] sel_start;
  logic [WIDTH-1:0] sel_end;
  logic [WIDTH-1:0] count;
  logic             up_dn_q;
  logic             aborted_q;
  logic             busy_q;
  logic             core_ld;
  logic             core_en;
  logic             at_end;

  // Arbitration and job selection while idle.
  always_comb begin
    gnt       = rr_pick(bus.req_valid, owner);
    sel_start = gnt ? bus.start1 : bus.start0;
    sel_end   = gnt ? bus.end1   : bus.end0;
    bus.req_ready = 2'b00;
    if (state == IDLE && |bus.req_valid) begin
      bus.req_ready = idx_onehot(gnt);
    end
  end

  // Counter control and state-decoded status outputs.
  always_comb begin
    at_end      = (count == end_q);
    core_ld     = (state == LOAD);
    core_en     = (state == RUN) && !at_end && !bus.abort;
    bus.done    = (state == DONE) ? idx_onehot(owner) : 2'b00;
    bus.aborted = (state == DONE) && aborted_q;
    bus.busy    = busy_q;
    bus.up_dn   = up_dn_q;
    bus.count   = count;
  end

  // Job sequencing FSM with registered job context.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      owner     <= 1'b1;
      start_q   <= '0;
      end_q     <= '0;
      up_dn_q   <= UP;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            start_q <= sel_start;
            end_q   <= sel_end;
            owner   <= gnt;
            up_dn_q <= (sel_end >= sel_start) ? UP : DN;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          state <= RUN;
        end
        RUN: begin
          // Reaching end wins over a simultaneous abort.
          if (at_end) begin
            aborted_q <= 1'b0;
            state     <= DONE;
          end else if (bus.abort) begin
            aborted_q <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  updn_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (core_ld),
    .en      (core_en),
    .up_dn   (up_dn_q),
    .data_in (start_q),
    .count   (count)
  );

endmodule

// File: tb/tb_updn_cnt_sched.sv
// Scoreboard bench for updn_cnt_sched (WIDTH=3) with directed jobs.
module tb_updn_cnt_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rv0, rv1, ab;
  logic [2:0] s0, e0, s1, e1;

  updn_cnt_sched_if #(.WIDTH(3)) bus ();

  assign bus.req_valid = {rv1, rv0};
  assign bus.start0    = s0;
  assign bus.end0      = e0;
  assign bus.start1    = s1;
  assign bus.end1      = e1;
  assign bus.abort     = ab;

  updn_cnt_sched #(.WIDTH(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int up;
    int start;
    int fin;
    int ab;
    int lat;
    int b2b;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   act = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_done_cyc = -100;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic push(int owner, int up, int start, int fin, int abrt, int lat, int b2b);
    exp_t x;
    x.owner = owner; x.up = up; x.start = start; x.fin = fin;
    x.ab = abrt; x.lat = lat; x.b2b = b2b;
    q.push_back(x);
  endtask

  // Monitor: pops the expected job at each accept and checks it at done.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        act = 0;
      end else begin
        if (bus.req_ready != 2'b00) begin
          if (q.size() == 0) begin
            fail_now("unexpected_accept");
          end else begin
            cur = q.pop_front();
            act = 1;
            acc_cyc = cyc;
            check("grant", int'(bus.req_ready), (cur.owner == 1) ? 2 : 1);
            if (cur.b2b != 0) check("b2b_gap", cyc - last_done_cyc, 1);
          end
        end
        if (act && cyc == acc_cyc + 1) check("busy_load", int'(bus.busy), 1);
        if (act && cyc == acc_cyc + 2) check("count_first", int'(bus.count), cur.start);
        if (bus.done != 2'b00) begin
          if (!act) begin
            fail_now("unexpected_done");
          end else begin
            check("done_owner", int'(bus.done), (cur.owner == 1) ? 2 : 1);
            check("aborted", int'(bus.aborted), cur.ab);
            check("count_final", int'(bus.count), cur.fin);
            check("latency", cyc - acc_cyc, cur.lat);
            check("up_dn", int'(bus.up_dn), cur.up);
            act = 0;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic submit(int r, int st, int en);
    bit got = 0;
    @(posedge clk); #1;
    if (r == 0) begin s0 = 3'(st); e0 = 3'(en); rv0 = 1'b1; end
    else        begin s1 = 3'(st); e1 = 3'(en); rv1 = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin got = 1; break; end
    end
    if (!got) fail_now("accept_timeout");
    @(posedge clk); #1;
    if (r == 0) rv0 = 1'b0; else rv1 = 1'b0;
  endtask

  task automatic abort_at(int v);
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy && int'(bus.count) == v) begin got = 1; break; end
    end
    if (!got) fail_now("abort_timeout");
    ab = 1'b1;
    @(posedge clk); #1;
    ab = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !act && !bus.busy) begin ok = 1; break; end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_count"},   int'(bus.count), 0);
    check({tag, "_busy"},    int'(bus.busy), 0);
    check({tag, "_up_dn"},   int'(bus.up_dn), 1);
    check({tag, "_ready"},   int'(bus.req_ready), 0);
    check({tag, "_done"},    int'(bus.done), 0);
    check({tag, "_aborted"}, int'(bus.aborted), 0);
  endtask

  initial begin
    reset_n = 1'b1;
    rv0 = 1'b0; rv1 = 1'b0; ab = 1'b0;
    s0 = '0; e0 = '0; s1 = '0; e1 = '0;
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset_n = 1'b0;

    // Basic up and down jobs.
    push(0, 1, 2, 6, 0, 7, 0);
    submit(0, 2, 6);
    wait_idle();
    repeat (3) @(negedge clk);
    check("count_hold", int'(bus.count), 6);

    push(1, 0, 5, 1, 0, 7, 0);
    submit(1, 5, 1);
    wait_idle();

    // Asynchronous reset while idle.
    @(posedge clk); #3;
    reset_n = 1'b1;
    #1;
    check_reset_outputs("rst_idle");
    @(posedge clk); #1;
    reset_n = 1'b0;

    // Range boundaries.
    push(1, 1, 7, 7, 0, 3, 0);
    submit(1, 7, 7);
    wait_idle();
    push(0, 1, 0, 7, 0, 10, 0);
    submit(0, 0, 7);
    wait_idle();
    push(1, 0, 7, 0, 0, 10, 0);
    submit(1, 7, 0);
    wait_idle();

    // Abort mid-run, then abort coinciding with reaching end.
    push(0, 1, 1, 4, 1, 6, 0);
    fork
      submit(0, 1, 6);
      abort_at(4);
    join
    wait_idle();
    push(1, 1, 1, 3, 0, 5, 0);
    fork
      submit(1, 1, 3);
      abort_at(3);
    join
    wait_idle();

    // Asynchronous reset mid-run on a requester-0 job.
    push(0, 1, 0, 7, 0, 10, 0);
    submit(0, 0, 7);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    check_reset_outputs("rst_run");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;

    // Contested back-to-back jobs: grants 0,1,0.
    push(0, 1, 0, 1, 0, 4, 0);
    push(1, 1, 0, 1, 0, 4, 1);
    push(0, 1, 0, 1, 0, 4, 1);
    fork
      begin submit(0, 0, 1); submit(0, 0, 1); end
      begin submit(1, 0, 1); end
    join
    wait_idle();
    repeat (3) @(negedge clk);
    check("final_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
